// File: rtl/xnor8_pkg.sv
// Shared ALU constants for the 8-bit datapath: default operand width and
// the opcode that selects the XNOR unit in the result mux.
package xnor8_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_XOR  = 4'h2,
        OP_XNOR = 4'h3
    } alu_op_e;

endpackage : xnor8_pkg

// File: rtl/xnor8_popcnt.sv
// Combinational popcount of a WIDTH-bit vector into CNT_W bits; shared by
// ALU flag logic that needs a count of set bits.
module xnor8_popcnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [CNT_W-1:0] cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + CNT_W'(vec[i]);
        end
    end

endmodule : xnor8_popcnt

// File: rtl/xnor8.sv
// Registered bitwise XNOR with equality flag and matching-bit count,
// one cycle of latency, all outputs straight from flops.
module xnor8
    import xnor8_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             eq,
    output logic [CNT_W-1:0] match_cnt,
    output logic             out_valid
);

    // Valid-only handshake (no ready): a/b are sampled on every edge where
    // in_valid=1; out_valid is high for exactly the cycle after each sample,
    // and z/eq/match_cnt keep the last sampled result while in_valid=0.

    logic [WIDTH-1:0] z_next;
    logic             eq_next;
    logic [CNT_W-1:0] cnt_next;

    assign z_next  = ~(a ^ b);
    assign eq_next = &z_next;

    xnor8_popcnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_popcnt (
        .vec (z_next),
        .cnt (cnt_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            eq        <= 1'b0;
            match_cnt <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z         <= z_next;
                eq        <= eq_next;
                match_cnt <= cnt_next;
            end
        end
    end

endmodule : xnor8

// File: tb/tb_xnor8.sv
// Self-checking bench for xnor8: directed vectors, reset, hold and
// back-to-back cases, then randomized traffic against a reference model.
module tb_xnor8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic       eq;
    logic [3:0] match_cnt;
    logic       out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: last result held by the unit, plus expected out_valid
    logic [7:0]  m_z;
    logic        m_eq;
    logic [3:0]  m_cnt;
    logic        m_valid;
    logic [12:0] exp_q[$];

    xnor8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .z         (z),
        .eq        (eq),
        .match_cnt (match_cnt),
        .out_valid (out_valid)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference: bit i of z is set when the operands agree at position i
    function automatic logic [12:0] ref_result(input logic [7:0] ra, input logic [7:0] rb);
        logic [7:0] rz;
        int         agree;
        rz    = 8'h00;
        agree = 0;
        for (int i = 0; i < 8; i++) begin
            if (ra[i] == rb[i]) begin
                rz[i] = 1'b1;
                agree = agree + 1;
            end
        end
        return {rz, (ra == rb), 4'(agree)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_z"},     32'(z),         32'(m_z));
        check({tag, "_eq"},    32'(eq),        32'(m_eq));
        check({tag, "_cnt"},   32'(match_cnt), 32'(m_cnt));
        check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    endtask

    task automatic model_reset();
        m_z     = 8'h00;
        m_eq    = 1'b0;
        m_cnt   = 4'd0;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    // driver: present one cycle of stimulus, check one edge later
    task automatic drive(input string tag, input logic v, input logic [7:0] da, input logic [7:0] db);
        @(negedge clk);
        in_valid = v;
        a        = da;
        b        = db;
        if (v) exp_q.push_back(ref_result(da, db));
        @(posedge clk);
        #1;
        m_valid = v;
        if (v) {m_z, m_eq, m_cnt} = exp_q.pop_front();
        check_outputs(tag);
    endtask

    // absolute checks for the directed vectors, independent of the model
    task automatic expect_abs(input string tag, input logic [7:0] ez, input logic ee, input logic [3:0] ec);
        check({tag, "_z_abs"},   32'(z),         32'(ez));
        check({tag, "_eq_abs"},  32'(eq),        32'(ee));
        check({tag, "_cnt_abs"}, 32'(match_cnt), 32'(ec));
    endtask

    logic [7:0] vec_a[6]  = '{8'b00010010, 8'b00010110, 8'b10010010, 8'b00011010, 8'b00110010, 8'b00010110};
    logic [7:0] vec_b[6]  = '{8'b01000101, 8'b01010101, 8'b01000111, 8'b00000101, 8'b11000101, 8'b01000001};
    logic [7:0] vec_z[6]  = '{8'b10101000, 8'b10111100, 8'b00101010, 8'b11100000, 8'b00001000, 8'b10101000};
    logic [3:0] vec_c[6]  = '{4'd3, 4'd5, 4'd3, 4'd3, 4'd1, 4'd3};

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        model_reset();
        #2;
        check_outputs("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            drive($sformatf("vec%0d", i), 1'b1, vec_a[i], vec_b[i]);
            expect_abs($sformatf("vec%0d", i), vec_z[i], 1'b0, vec_c[i]);
        end

        // equality boundaries
        drive("equal", 1'b1, 8'b10110011, 8'b10110011);
        expect_abs("equal", 8'hFF, 1'b1, 4'd8);
        drive("inverse", 1'b1, 8'b00000000, 8'b11111111);
        expect_abs("inverse", 8'h00, 1'b0, 4'd0);

        // hold
        drive("hold_load", 1'b1, 8'b00010011, 8'b01000100);
        expect_abs("hold_load", 8'b10101000, 1'b0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            drive($sformatf("hold%0d", i), 1'b0, 8'(i * 37 + 5), 8'(i * 91 + 200));
            expect_abs($sformatf("hold%0d", i), 8'b10101000, 1'b0, 4'd3);
        end

        // back-to-back
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive($sformatf("b2b%0d", i), 1'b1, 8'b10110011, 8'b10110011);
            else            drive($sformatf("b2b%0d", i), 1'b1, 8'b00000000, 8'b11111111);
        end

        // reset asserted mid-stream with in_valid high
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h5A;
        b        = 8'h5A;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        drive("rst_release_idle", 1'b0, 8'h12, 8'h34);
        drive("rst_first_valid", 1'b1, 8'h0F, 8'h0F);

        // random traffic
        for (int i = 0; i < 1000; i++) begin
            drive("rand", ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_xnor8

// File: doc/xnor8.md
# xnor8

Registered 8-bit bitwise XNOR unit for the 8-bit ALU datapath. It computes z = ~(a ^ b) per bit and derives two comparison results from that vector: an equality flag and a count of matching bit positions. All results are registered with a one-cycle latency and a simple valid qualifier, so the ALU result mux can sample them without extra pipeline logic.

## Interface
- WIDTH, default 8: operand and result width. Only 8 is required to be verified.
- CNT_W, default 4: width of match_cnt, equal to $clog2(WIDTH+1).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands on a and b are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- z  output  WIDTH  registered bitwise XNOR of a and b.
- eq  output  1  registered flag, 1 when a == b (z is all ones).
- match_cnt  output  CNT_W  registered count of bit positions where a[i] == b[i] (popcount of z).
- out_valid  output  1  z, eq and match_cnt hold a fresh result.

## Operation
- Combinational core:
  - z_next[i] = ~(a[i] ^ b[i]) for every i.
  - eq_next = &z_next.
  - match_cnt_next = popcount(z_next), range 0..WIDTH, unsigned, never overflows CNT_W.
- On a rising edge with in_valid=1: z, eq and match_cnt load their next values.
- On a rising edge with in_valid=0: z, eq and match_cnt hold their previous values.
- out_valid is in_valid delayed by one cycle. It is updated on every edge.
- No X-propagation masking is required. Unknown input bits may produce unknown outputs only while in_valid=1.

## Timing
- Latency: exactly 1 cycle from the sampling edge to the outputs. Throughput is one operation per cycle, and back-to-back in_valid is supported.
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock): z=0, eq=0, match_cnt=0, out_valid=0.
- Reset release: the first edge with rst_n=1 samples normally.
- Reset asserted mid-operation: any in-flight result is discarded, and out_valid is 0 on the next cycle even if in_valid was 1 before reset.
- Boundary cases:
  - a == b gives z=8'hFF, eq=1, match_cnt=8.
  - a == ~b gives z=8'h00, eq=0, match_cnt=0.
- All outputs are driven directly from flops. There is no combinational path from inputs to outputs.

## Structure
- Shared ALU package holds the WIDTH default (ALU_W = 8) and an opcode constant for XNOR. The CNT_W derivation lives in this block.
- One sub-module, xnor8_popcnt: a parameterized combinational popcount of the WIDTH-bit vector to CNT_W bits, reusable by other ALU flag logic.
- Top level contains the XNOR vector, the eq reduction, the popcount instance and the four output registers.

## Test plan
- Reset: assert rst_n=0 mid-stream with in_valid=1 -> z=00000000, eq=0, match_cnt=0, out_valid=0 immediately, and stays so until the first valid sample after release.
- Vector sequence, in_valid=1 each cycle, checked one cycle later:
  - 00010010/01000101 -> 10101000, cnt 3.
  - 00010110/01010101 -> 10111100, cnt 5.
  - 10010010/01000111 -> 00101010, cnt 3.
  - 00011010/00000101 -> 11100000, cnt 3.
  - 00110010/11000101 -> 00001000, cnt 1.
  - 00010110/01000001 -> 10101000, cnt 3.
  - eq=0 for all of these.
- Equality: a=b=10110011 -> z=11111111, eq=1, match_cnt=8. Then a=00000000, b=11111111 -> z=00000000, eq=0, match_cnt=0.
- Hold: load 00010011/01000100, giving z=10101000. Then drop in_valid and change a and b for 3 cycles -> z, eq and match_cnt unchanged, out_valid=0.
- Back-to-back: alternate the two equality vectors above for 10 consecutive cycles -> each result appears exactly one cycle later, with out_valid=1 throughout.
- Random: 1000 random a/b pairs with random in_valid, compared against a reference model for all outputs including the hold behaviour.
